nibble_packer: RTL and testbench
================================

Name: nibble_packer

Overview:
- Upstream feeder for the nibble-maximum pipeline.
- Accepts a serial stream of 4-bit nibbles over a valid/ready handshake and packs every four into a 16-bit word.
- Buffers packed words in a small show-ahead FIFO and presents the head word on NIBBLES, which drives the 16-bit nibble input of the downstream maximum-select stage.
- A FLUSH request closes a partially filled word, zero-padded.

Parameters:
- FIFO_DEPTH, 4, number of 16-bit word entries in the output FIFO; must be a power of 2, minimum 2.
- ADDR_W, 2, FIFO pointer width; 2**ADDR_W must equal FIFO_DEPTH.

Ports:
- CLK  input  1  block clock; all state updates on posedge.
- RESET_L  input  1  reset, asynchronous, active-low.
- IN_NIBBLE  input  4  incoming nibble.
- IN_VALID  input  1  IN_NIBBLE is valid this cycle.
- FLUSH  input  1  request to close the current partial word; qualified by IN_READY.
- IN_READY  output  1  block can accept a nibble/FLUSH this cycle.
- NIBBLES  output  16  head FIFO word; feeds the downstream nibble-maximum stage.
- OUT_VALID  output  1  NIBBLES holds a valid word.
- OUT_READY  input  1  downstream consumes head word this cycle.
- FIFO_FULL  output  1  FIFO holds FIFO_DEPTH words.
- WORD_COUNT  output  8  total words pushed since reset, wraps 255->0.

Behaviour:
- Reset:
  - Asynchronous on RESET_L low: assembly register, nibble index, FIFO pointers and occupancy, and WORD_COUNT all clear to 0.
  - NIBBLES=0, OUT_VALID=0, FIFO_FULL=0.
  - IN_READY=0 while RESET_L is low.
  - Reset mid-word or with a non-empty FIFO discards all content, with no output glitch beyond going to reset values.
- Handshakes:
  - IN_READY = RESET_L & ~FIFO_FULL.
  - A nibble is accepted on a posedge with IN_VALID & IN_READY.
  - FLUSH is acted on only on a posedge with IN_READY=1; if FIFO_FULL, upstream must hold FLUSH.
- Assembly state (nibble index idx): states FILL0..FILL3.
  - Accepted nibble goes to lane idx: FILL0 -> NIBBLES[3:0], FILL1 -> [7:4], FILL2 -> [11:8], FILL3 -> [15:12].
  - idx advances by 1 per accepted nibble.
  - Acceptance in FILL3 pushes {IN_NIBBLE, asm[11:0]} into the FIFO in the same edge, returns to FILL0 and clears the assembly register.
- FLUSH:
  - Accepted FLUSH with a nibble accepted in the same cycle: the nibble is placed first, then the word is pushed with unfilled upper lanes = 0, and idx returns to 0.
  - If the nibble completes the word in FILL3, this is a normal push, exactly one word.
  - FLUSH with idx=0 and no nibble: no push, no effect.
  - FLUSH with idx>0 and no nibble: push zero-padded partial word, idx=0.
- FIFO:
  - Show-ahead: NIBBLES = head entry combinationally from storage; NIBBLES=0 when empty.
  - OUT_VALID = ~empty.
  - Pop on OUT_VALID & OUT_READY; OUT_READY while empty is ignored.
  - Push and pop in the same edge: occupancy unchanged, both pointers advance.
  - Push is never attempted when full, since IN_READY=0. No bypass: an empty FIFO plus push makes OUT_VALID rise after that edge.
  - Latency: 4th nibble accepted at edge k -> word visible on NIBBLES with OUT_VALID=1 in the cycle after edge k.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is ADDR_W+1; FIFO_FULL = (count==FIFO_DEPTH).
- WORD_COUNT: +1 per push, including padded flush words; 8-bit wrap.

Test Plan:
- Reset then IN_VALID nibbles 1,2,3,4 on consecutive cycles, OUT_READY=0 -> cycle after 4th accept: OUT_VALID=1, NIBBLES=16'h4321, WORD_COUNT=1.
- Push 4 words (16'h4321, 16'h8765, 16'hCBA9, 16'h0FED) with OUT_READY=0 -> FIFO_FULL=1, IN_READY=0; a held 17th nibble is not accepted. Then OUT_READY=1 -> words pop in order, one per cycle, IN_READY=1 after first pop.
- Nibbles 5,6 then FLUSH alone -> NIBBLES=16'h0065 pushed. FLUSH again with idx=0 -> no push, WORD_COUNT unchanged.
- Nibbles A,B,C, then D with FLUSH the same cycle -> exactly one word 16'hDCBA, WORD_COUNT+1.
- FIFO holding 2 words, simultaneous completing push and pop -> occupancy stays 2, next head correct.
- Assert RESET_L low asynchronously mid-word (idx=2) with FIFO holding 3 words -> outputs clear immediately without waiting for CLK. After release, nibbles 1,2,3,4 -> 16'h4321 with no leftover lanes.

Source files
------------

// File: rtl/nibble_packer_if.sv
// nibble_packer_if: handshake/bus bundle for nibble_packer.
//   Upstream side : IN_NIBBLE/IN_VALID/FLUSH in, IN_READY back.
//   Downstream    : NIBBLES/OUT_VALID out, OUT_READY back.
//   Status        : FIFO_FULL, WORD_COUNT.
// master = the environment driving the packer, slave = the packer itself.
interface nibble_packer_if;
  logic [3:0]  IN_NIBBLE;
  logic        IN_VALID;
  logic        FLUSH;
  logic        IN_READY;
  logic [15:0] NIBBLES;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        FIFO_FULL;
  logic [7:0]  WORD_COUNT;

  modport master (
    output IN_NIBBLE, IN_VALID, FLUSH, OUT_READY,
    input  IN_READY, NIBBLES, OUT_VALID, FIFO_FULL, WORD_COUNT
  );

  modport slave (
    input  IN_NIBBLE, IN_VALID, FLUSH, OUT_READY,
    output IN_READY, NIBBLES, OUT_VALID, FIFO_FULL, WORD_COUNT
  );
endinterface

// File: rtl/nibble_packer.sv
// nibble_packer: packs a serial nibble stream, four at a time, into 16-bit
// words (first nibble in the low lane) and queues them in a show-ahead FIFO
// whose head drives NIBBLES for the downstream nibble-maximum stage.
// FLUSH closes a partial word with zero upper lanes.
//   CLK, RESET_L : clock, async active-low reset
//   bus (slave)  : IN_NIBBLE/IN_VALID/FLUSH/IN_READY upstream,
//                  NIBBLES/OUT_VALID/OUT_READY downstream,
//                  FIFO_FULL, WORD_COUNT (words pushed since reset, wraps)
module nibble_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic           CLK,
  input  logic           RESET_L,
  nibble_packer_if.slave bus
);
  typedef enum logic [1:0] {FILL0, FILL1, FILL2, FILL3} fill_e;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  fill_e             idx;
  logic [3:0][3:0]   asm_q, asm_nxt;
  logic [15:0]       mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [7:0]        word_cnt;
  logic              full, empty, in_rdy, acc_nib, acc_fl, push, pop;

  always_comb begin
    full    = (count == DEPTH_C);
    empty   = (count == '0);
    in_rdy  = RESET_L & ~full;
    acc_nib = bus.IN_VALID & in_rdy;
    acc_fl  = bus.FLUSH & in_rdy;
    // Lanes above idx are always zero (cleared on every push), so the
    // merged word is already zero-padded when a flush closes it early.
    asm_nxt = asm_q;
    if (acc_nib) asm_nxt[idx] = bus.IN_NIBBLE;
    // A flush closes the word only if it holds at least one nibble after
    // this cycle's acceptance; a completing nibble plus flush is one push.
    push    = (acc_nib && idx == FILL3) ||
              (acc_fl && (acc_nib || idx != FILL0));
    pop     = ~empty & bus.OUT_READY;
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      idx      <= FILL0;
      asm_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_cnt <= '0;
    end else begin
      if (push) begin
        idx      <= FILL0;
        asm_q    <= '0;
        wr_ptr   <= wr_ptr + PTR_ONE;
        word_cnt <= word_cnt + 8'd1;
      end else if (acc_nib) begin
        idx   <= fill_e'(idx + 2'd1);
        asm_q <= asm_nxt;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: it is only observed through a non-empty count.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= asm_nxt;
  end

  assign bus.IN_READY   = in_rdy;
  assign bus.NIBBLES    = empty ? 16'h0 : mem[rd_ptr];
  assign bus.OUT_VALID  = ~empty;
  assign bus.FIFO_FULL  = full;
  assign bus.WORD_COUNT = word_cnt;
endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of the packer.
module tb_nibble_packer;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RESET_L = 1'b0;
  nibble_packer_if bus();

  nibble_packer #(.FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: completed words, nibbles of the open word, push count.
  logic [15:0] m_q[$];
  logic [3:0]  m_part[$];
  logic [7:0]  m_wc = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("in_ready",   32'(bus.IN_READY),   32'(m_q.size() < DEPTH));
    chk("out_valid",  32'(bus.OUT_VALID),  32'(m_q.size() != 0));
    chk("nibbles",    32'(bus.NIBBLES),    (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    chk("fifo_full",  32'(bus.FIFO_FULL),  32'(m_q.size() == DEPTH));
    chk("word_count", 32'(bus.WORD_COUNT), 32'(m_wc));
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    bit rdy = (m_q.size() < DEPTH);
    bit close = 1'b0;
    logic [15:0] w = 16'h0;
    if (rdy && bus.IN_VALID) m_part.push_back(bus.IN_NIBBLE);
    if (m_part.size() == 4 || (rdy && bus.FLUSH && m_part.size() > 0)) begin
      for (int i = 0; i < m_part.size(); i++) w = w | (16'(m_part[i]) << (4 * i));
      m_part.delete();
      close = 1'b1;
    end
    if (m_q.size() > 0 && bus.OUT_READY) void'(m_q.pop_front());
    if (close) begin
      m_q.push_back(w);
      m_wc = m_wc + 8'd1;
    end
  endtask

  // Called just after a posedge; returns just after the next posedge.
  task automatic cycle(input logic [3:0] n, input logic v, input logic fl, input logic ordy);
    bus.IN_NIBBLE = n;
    bus.IN_VALID  = v;
    bus.FLUSH     = fl;
    bus.OUT_READY = ordy;
    @(negedge CLK);
    model_check();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic feed4(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] t = w >> (4 * i);
      cycle(t[3:0], 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    RESET_L = 1'b0;
    bus.IN_NIBBLE = '0; bus.IN_VALID = 1'b0; bus.FLUSH = 1'b0; bus.OUT_READY = 1'b0;
    m_q.delete(); m_part.delete(); m_wc = 8'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready",  32'(bus.IN_READY),   32'h0);
    chk("rst_out_valid", 32'(bus.OUT_VALID),  32'h0);
    chk("rst_nibbles",   32'(bus.NIBBLES),    32'h0);
    chk("rst_full",      32'(bus.FIFO_FULL),  32'h0);
    chk("rst_wc",        32'(bus.WORD_COUNT), 32'h0);
    RESET_L = 1'b1;
  endtask

  initial begin
    do_reset();

    // First word and its latency.
    feed4(16'h4321);
    chk("t1_valid", 32'(bus.OUT_VALID),  32'h1);
    chk("t1_word",  32'(bus.NIBBLES),    32'h4321);
    chk("t1_wc",    32'(bus.WORD_COUNT), 32'h1);

    // Fill the FIFO, hold a nibble against backpressure, then drain in order.
    feed4(16'h8765); feed4(16'hCBA9); feed4(16'h0FED);
    chk("t2_full",  32'(bus.FIFO_FULL), 32'h1);
    chk("t2_rdy",   32'(bus.IN_READY),  32'h0);
    cycle(4'h1, 1'b1, 1'b0, 1'b0);
    cycle(4'h1, 1'b1, 1'b0, 1'b0);
    chk("t2_wc_held", 32'(bus.WORD_COUNT), 32'h4);
    chk("t2_head",    32'(bus.NIBBLES),    32'h4321);
    cycle(4'h0, 1'b0, 1'b0, 1'b1);
    chk("t2_pop1",  32'(bus.NIBBLES),  32'h8765);
    chk("t2_rdy1",  32'(bus.IN_READY), 32'h1);
    cycle(4'h0, 1'b0, 1'b0, 1'b1);
    chk("t2_pop2",  32'(bus.NIBBLES), 32'hCBA9);
    cycle(4'h0, 1'b0, 1'b0, 1'b1);
    chk("t2_pop3",  32'(bus.NIBBLES), 32'h0FED);
    cycle(4'h0, 1'b0, 1'b0, 1'b1);
    chk("t2_empty", 32'(bus.OUT_VALID), 32'h0);

    // Flush of a partial word, then a flush with nothing open.
    cycle(4'h5, 1'b1, 1'b0, 1'b0);
    cycle(4'h6, 1'b1, 1'b0, 1'b0);
    cycle(4'h0, 1'b0, 1'b1, 1'b0);
    chk("t3_word", 32'(bus.NIBBLES),    32'h0065);
    chk("t3_wc",   32'(bus.WORD_COUNT), 32'h5);
    cycle(4'h0, 1'b0, 1'b1, 1'b0);
    chk("t3_wc_idle", 32'(bus.WORD_COUNT), 32'h5);
    cycle(4'h0, 1'b0, 1'b0, 1'b1);
    chk("t3_one_word", 32'(bus.OUT_VALID), 32'h0);

    // Completing nibble together with flush: exactly one word.
    cycle(4'hA, 1'b1, 1'b0, 1'b0);
    cycle(4'hB, 1'b1, 1'b0, 1'b0);
    cycle(4'hC, 1'b1, 1'b0, 1'b0);
    cycle(4'hD, 1'b1, 1'b1, 1'b0);
    chk("t4_word", 32'(bus.NIBBLES),    32'hDCBA);
    chk("t4_wc",   32'(bus.WORD_COUNT), 32'h6);
    cycle(4'h0, 1'b0, 1'b0, 1'b1);
    chk("t4_one_word", 32'(bus.OUT_VALID), 32'h0);

    // Simultaneous push and pop with two words queued.
    feed4(16'h1111); feed4(16'h2222);
    cycle(4'h3, 1'b1, 1'b0, 1'b0);
    cycle(4'h3, 1'b1, 1'b0, 1'b0);
    cycle(4'h3, 1'b1, 1'b0, 1'b0);
    cycle(4'h3, 1'b1, 1'b0, 1'b1);
    chk("t5_head", 32'(bus.NIBBLES), 32'h2222);
    cycle(4'h0, 1'b0, 1'b0, 1'b1);
    chk("t5_next", 32'(bus.NIBBLES), 32'h3333);
    cycle(4'h0, 1'b0, 1'b0, 1'b1);
    chk("t5_empty", 32'(bus.OUT_VALID), 32'h0);
    chk("t5_wc",    32'(bus.WORD_COUNT), 32'h9);

    // Asynchronous reset mid-word with three words queued.
    feed4(16'h5A5A); feed4(16'h6B6B); feed4(16'h7C7C);
    cycle(4'h9, 1'b1, 1'b0, 1'b0);
    cycle(4'h8, 1'b1, 1'b0, 1'b0);
    #2;
    RESET_L = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.OUT_VALID),  32'h0);
    chk("ar_nib",   32'(bus.NIBBLES),    32'h0);
    chk("ar_rdy",   32'(bus.IN_READY),   32'h0);
    chk("ar_full",  32'(bus.FIFO_FULL),  32'h0);
    chk("ar_wc",    32'(bus.WORD_COUNT), 32'h0);
    m_q.delete(); m_part.delete(); m_wc = 8'd0;
    @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    feed4(16'h4321);
    chk("ar_word", 32'(bus.NIBBLES),    32'h4321);
    chk("ar_wc1",  32'(bus.WORD_COUNT), 32'h1);

    // Randomized traffic with bursts of backpressure.
    for (int c = 0; c < 600; c++) begin
      logic ordy;
      ordy = ((c / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, ordy);
    end
    for (int c = 0; c < 8; c++) cycle(4'h0, 1'b0, 1'b0, 1'b1);
    chk("drain_empty", 32'(bus.OUT_VALID), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
